// File: rtl/seq_bcd2bin_converter.sv
// Sequential signed BCD-to-binary converter (reverse double-dabble, one bit per cycle).
// Optional macro SEQ_BCD2BIN_SATURATE_EN: saturate bin on overflow instead of wrapping.
module seq_bcd2bin_converter #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned WIDTH       = 16,
  parameter bit          CHECK_PARAM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             negative,
  input  logic [3:0]       bcd [NUM_DIGITS],
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] bin,
  output logic             invalid,
  output logic             overflow
);

  localparam int unsigned BW = 4 * NUM_DIGITS;
  localparam int unsigned CW = (BW > 1) ? $clog2(BW) : 1;
  localparam int unsigned EW = ((BW > WIDTH) ? BW : WIDTH) + 1;
  localparam logic [CW-1:0] CntLoad = CW'(BW - 1);
  localparam logic [EW-1:0] Lim     = EW'(1) << (WIDTH - 1);

  if (CHECK_PARAM && (NUM_DIGITS == 0 || WIDTH < 2)) begin : g_param_check
    $fatal(1, "seq_bcd2bin_converter: illegal NUM_DIGITS/WIDTH combination");
  end

  typedef enum logic [1:0] {StIdle, StShift, StSign, StDone} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     sbcd_q, sbcd_d;
  logic [BW-1:0]     sbin_q, sbin_d;
  logic              neg_q, neg_d;
  logic              skip_q, skip_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic              invalid_q, invalid_d;
  logic              overflow_q, overflow_d;

  logic              digit_bad;
  logic [BW-1:0]     bcd_flat;
  logic [BW-1:0]     shifted;
  logic [BW-1:0]     step_bcd;
  logic [EW-1:0]     mag_ext;
  logic              ovf_now;
  logic [WIDTH-1:0]  res;

  always_comb begin
    digit_bad = 1'b0;
    bcd_flat  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      bcd_flat[4*i +: 4] = bcd[i];
      if (bcd[i] > 4'd9) digit_bad = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then correct any digit that picked up an 8.
  assign shifted = sbcd_q >> 1;
  always_comb begin
    step_bcd = shifted;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (shifted[4*i +: 4] >= 4'd8) step_bcd[4*i +: 4] = shifted[4*i +: 4] - 4'd3;
    end
  end

  assign mag_ext = EW'(sbin_q);

  always_comb begin
    ovf_now = neg_q ? (mag_ext > Lim) : (mag_ext >= Lim);
    res     = neg_q ? WIDTH'(EW'(0) - mag_ext) : WIDTH'(mag_ext);
`ifdef SEQ_BCD2BIN_SATURATE_EN
    if (ovf_now) res = neg_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sbcd_d     = sbcd_q;
    sbin_d     = sbin_q;
    neg_d      = neg_q;
    skip_d     = skip_q;
    bin_d      = bin_q;
    invalid_d  = invalid_q;
    overflow_d = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          neg_d      = negative;
          sbcd_d     = bcd_flat;
          sbin_d     = '0;
          cnt_d      = CntLoad;
          invalid_d  = digit_bad;
          overflow_d = 1'b0;
          skip_d     = digit_bad;
          if (digit_bad) bin_d = '0;
          // Invalid operands pass through SIGN as a no-op so done lands one cycle later.
          state_d    = digit_bad ? StSign : StShift;
        end
      end
      StShift: begin
        sbin_d = {sbcd_q[0], sbin_q[BW-1:1]};
        sbcd_d = step_bcd;
        if (cnt_q == '0) begin
          state_d = StSign;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSign: begin
        if (!skip_q) begin
          overflow_d = ovf_now;
          bin_d      = res;
        end
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sbcd_q     <= '0;
      sbin_q     <= '0;
      neg_q      <= 1'b0;
      skip_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bin_q      <= '0;
      invalid_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (en) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sbcd_q     <= sbcd_d;
      sbin_q     <= sbin_d;
      neg_q      <= neg_d;
      skip_q     <= skip_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bin_q      <= bin_d;
      invalid_q  <= invalid_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bin      = bin_q;
  assign invalid  = invalid_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_bcd2bin_converter.sv
// Scoreboard bench for seq_bcd2bin_converter: a 4-digit/16-bit and a 3-digit/8-bit instance.
module tb_seq_bcd2bin_converter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en;
  logic        start4, neg4, busy4, done4, inv4, ovf4;
  logic [3:0]  bcd4 [4];
  logic [15:0] bin4;
  logic        start3, neg3, busy3, done3, inv3, ovf3;
  logic [3:0]  bcd3 [3];
  logic [7:0]  bin3;

  seq_bcd2bin_converter #(.NUM_DIGITS(4), .WIDTH(16), .CHECK_PARAM(1'b1)) dut4 (
    .clk(clk), .rst(rst), .en(en), .start(start4), .negative(neg4), .bcd(bcd4),
    .busy(busy4), .done(done4), .bin(bin4), .invalid(inv4), .overflow(ovf4)
  );

  seq_bcd2bin_converter #(.NUM_DIGITS(3), .WIDTH(8), .CHECK_PARAM(1'b1)) dut3 (
    .clk(clk), .rst(rst), .en(en), .start(start3), .negative(neg3), .bcd(bcd3),
    .busy(busy3), .done(done3), .bin(bin3), .invalid(inv3), .overflow(ovf3)
  );

`ifdef SEQ_BCD2BIN_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  typedef struct {
    longint bin;
    bit     inv;
    bit     ovf;
    int     cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  exp_t m4, m3;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Decimal arithmetic reference: value, range test, then clamp or wrap to w bits.
  function automatic exp_t model(input int n, input int w, input bit neg, input int d[4]);
    exp_t   e;
    longint mag = 0, p = 1, val, lim;
    bit     bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (d[i] > 9) bad = 1'b1;
      mag += longint'(d[i]) * p;
      p   *= 10;
    end
    e.cyc = 0;
    if (bad) begin
      e.bin = 0; e.inv = 1'b1; e.ovf = 1'b0;
      return e;
    end
    lim   = longint'(1) << (w - 1);
    val   = neg ? -mag : mag;
    e.inv = 1'b0;
    e.ovf = (val > lim - 1) || (val < -lim);
    if (e.ovf && Sat) val = neg ? -lim : lim - 1;
    e.bin = val & ((longint'(1) << w) - 1);
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h (%0d), required 0x%0h (%0d) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done4_unexpected: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        m4 = q4.pop_front();
        chk("dut4_bin", longint'(bin4), m4.bin);
        chk("dut4_invalid", longint'(inv4), longint'(m4.inv));
        chk("dut4_overflow", longint'(ovf4), longint'(m4.ovf));
        chk("dut4_done_cycle", longint'(cyc), longint'(m4.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      if (q3.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done3_unexpected: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        m3 = q3.pop_front();
        chk("dut3_bin", longint'(bin3), m3.bin);
        chk("dut3_invalid", longint'(inv3), longint'(m3.inv));
        chk("dut3_overflow", longint'(ovf3), longint'(m3.ovf));
        chk("dut3_done_cycle", longint'(cyc), longint'(m3.cyc));
      end
    end
  end

  function automatic bit busy_of(input int which);
    return (which == 4) ? busy4 : busy3;
  endfunction

  function automatic int qsize(input int which);
    return (which == 4) ? q4.size() : q3.size();
  endfunction

  task automatic drive(input int which, input bit neg, input int d[4], input bit st);
    if (which == 4) begin
      neg4 = neg; start4 = st;
      for (int i = 0; i < 4; i++) bcd4[i] = 4'(d[i]);
    end else begin
      neg3 = neg; start3 = st;
      for (int i = 0; i < 3; i++) bcd3[i] = 4'(d[i]);
    end
  endtask

  task automatic scramble(input int which, input bit st);
    int r[4];
    for (int i = 0; i < 4; i++) r[i] = int'($urandom_range(0, 15));
    drive(which, 1'($urandom_range(0, 1)), r, st);
  endtask

  task automatic wait_idle(input int which);
    int t = 0;
    while (busy_of(which) && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle%0d: got busy=1 after 100 cycles, required busy=0", which);
    end
  endtask

  task automatic convert(input int which, input bit neg, input int d[4], input bit poke,
                         input int stall_len);
    exp_t e;
    int   n, lat, c, t;
    n   = (which == 4) ? 4 : 3;
    e   = model(n, (which == 4) ? 16 : 8, neg, d);
    lat = e.inv ? 1 : 4 * n + 1;
    wait_idle(which);
    @(posedge clk); #1;
    drive(which, neg, d, 1'b1);
    c     = cyc;
    e.cyc = c + 1 + lat + stall_len;
    if (which == 4) q4.push_back(e); else q3.push_back(e);
    @(posedge clk); #1;
    scramble(which, 1'b0);
    chk("busy_after_start", longint'(busy_of(which)), 1);
    if (poke) begin
      @(posedge clk); #1;
      scramble(which, 1'b1);
      @(posedge clk); #1;
      scramble(which, 1'b0);
    end
    if (stall_len > 0) begin
      @(posedge clk); #1;
      en = 1'b0;
      repeat (stall_len) @(posedge clk);
      #1 en = 1'b1;
    end
    t = 0;
    while (qsize(which) != 0 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL done%0d_timeout: got no done within 200 cycles, required done", which);
      if (which == 4) q4.delete(); else q3.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    if (which == 4) begin
      chk("dut4_bin_hold", longint'(bin4), e.bin);
      chk("dut4_invalid_hold", longint'(inv4), longint'(e.inv));
    end else begin
      chk("dut3_bin_hold", longint'(bin3), e.bin);
      chk("dut3_overflow_hold", longint'(ovf3), longint'(e.ovf));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d[4];
    int v;
    rst = 1'b1; en = 1'b1;
    d = '{0, 0, 0, 0};
    drive(4, 1'b0, d, 1'b0);
    drive(3, 1'b0, d, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy4", longint'(busy4), 0);
    chk("rst_done4", longint'(done4), 0);
    chk("rst_bin4", longint'(bin4), 0);
    chk("rst_flags4", longint'({inv4, ovf4}), 0);
    chk("rst_busy3", longint'(busy3), 0);
    chk("rst_bin3", longint'(bin3), 0);
    rst = 1'b0;

    d = '{4, 3, 2, 1}; convert(4, 1'b0, d, 1'b0, 0);
    d = '{9, 9, 9, 9}; convert(4, 1'b1, d, 1'b0, 0);
    d = '{0, 0, 0, 0}; convert(4, 1'b1, d, 1'b0, 0);
    d = '{4, 3, 10, 1}; convert(4, 1'b0, d, 1'b0, 0);
    d = '{2, 4, 0, 0}; convert(4, 1'b0, d, 1'b0, 0);
    d = '{4, 3, 2, 1}; convert(4, 1'b0, d, 1'b0, 5);
    d = '{8, 7, 6, 5}; convert(4, 1'b1, d, 1'b1, 0);

    d = '{0, 0, 2, 0}; convert(3, 1'b0, d, 1'b0, 0);
    d = '{8, 2, 1, 0}; convert(3, 1'b1, d, 1'b0, 0);
    d = '{9, 2, 1, 0}; convert(3, 1'b1, d, 1'b0, 0);
    d = '{7, 2, 1, 0}; convert(3, 1'b0, d, 1'b0, 0);
    d = '{8, 2, 1, 0}; convert(3, 1'b0, d, 1'b0, 0);
    d = '{9, 9, 9, 0}; convert(3, 1'b1, d, 1'b0, 0);
    d = '{15, 0, 0, 0}; convert(3, 1'b0, d, 1'b0, 0);

    // Abort mid-conversion; a done after this would be flagged by the monitor.
    d = '{4, 3, 2, 1}; convert(4, 1'b0, d, 1'b0, 0);
    wait_idle(4);
    d = '{9, 9, 9, 9};
    @(posedge clk); #1;
    drive(4, 1'b1, d, 1'b1);
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy4", longint'(busy4), 0);
    chk("abort_bin4", longint'(bin4), 0);
    chk("abort_flags4", longint'({inv4, ovf4, done4}), 0);
    repeat (30) @(posedge clk);
    #1;

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++) d[i] = int'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) d[$urandom_range(0, 3)] = int'($urandom_range(10, 15));
      v = (k % 5 == 4 && model(4, 16, 1'b0, d).inv == 1'b0) ? int'($urandom_range(1, 4)) : 0;
      convert(4, 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), v);
    end
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++) d[i] = int'($urandom_range(0, 9));
      if ($urandom_range(0, 2) == 0) begin
        v = int'($urandom_range(126, 129));
        d[0] = v % 10; d[1] = (v / 10) % 10; d[2] = v / 100;
      end
      if ($urandom_range(0, 5) == 0) d[$urandom_range(0, 2)] = int'($urandom_range(10, 15));
      convert(3, 1'($urandom_range(0, 1)), d, 1'b0, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("q4_drained", longint'(q4.size()), 0);
    chk("q3_drained", longint'(q3.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
